// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem request/ack, one-entry skid buffer and redirect kill.
// Define IF_ADDR_CHECK_EN to trap misaligned fetch addresses into a HALT state.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_addr_err
);

`ifdef IF_ADDR_CHECK_EN
    typedef enum logic [1:0] {S_FETCH, S_FULL, S_KILL, S_HALT} state_e;
`else
    typedef enum logic [1:0] {S_FETCH, S_FULL, S_KILL} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_pc4_q, out_pc4_d;
    logic        out_err_q, out_err_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic xfer;
    logic ack;
    logic misaligned;

`ifdef IF_ADDR_CHECK_EN
    assign misaligned = (req_addr_q[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign xfer      = out_valid_q && id_ready;
    assign imem_req  = !rst && ((state_q == S_FETCH && !misaligned) || state_q == S_KILL);
    assign ack       = imem_ack && imem_req;
    assign imem_addr = req_addr_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        out_pc4_d    = out_pc4_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (xfer) out_valid_d = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                if (redirect_valid) begin
                    // Without an ack the old request is still owed a response, so drain it first.
                    if (ack || misaligned) req_addr_d = redirect_pc;
                    else                   state_d    = S_KILL;
                end
`ifdef IF_ADDR_CHECK_EN
                else if (misaligned) begin
                    if (!out_valid_q || xfer) begin
                        out_valid_d = 1'b1;
                        out_instr_d = 32'h0;
                        out_pc_d    = req_addr_q;
                        out_pc4_d   = req_addr_q + 32'd4;
                        out_err_d   = 1'b1;
                        state_d     = S_HALT;
                    end
                end
`endif
                else if (ack) begin
                    pc_d       = req_addr_q + 32'd4;
                    req_addr_d = req_addr_q + 32'd4;
                    if (!out_valid_q || xfer) begin
                        out_valid_d = 1'b1;
                        out_instr_d = imem_rdata;
                        out_pc_d    = req_addr_q;
                        out_pc4_d   = req_addr_q + 32'd4;
                        out_err_d   = 1'b0;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = req_addr_q;
                        state_d      = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (redirect_valid) begin
                    req_addr_d = redirect_pc;
                    state_d    = S_FETCH;
                end else if (xfer) begin
                    out_valid_d  = 1'b1;
                    out_instr_d  = skid_instr_q;
                    out_pc_d     = skid_pc_q;
                    out_pc4_d    = skid_pc_q + 32'd4;
                    out_err_d    = 1'b0;
                    skid_valid_d = 1'b0;
                    state_d      = S_FETCH;
                end
            end
            S_KILL: begin
                if (ack) begin
                    req_addr_d = redirect_valid ? redirect_pc : pc_q;
                    state_d    = S_FETCH;
                end
            end
`ifdef IF_ADDR_CHECK_EN
            S_HALT: begin
                if (redirect_valid) begin
                    req_addr_d = redirect_pc;
                    state_d    = S_FETCH;
                end
            end
`endif
            default: state_d = S_FETCH;
        endcase

        if (redirect_valid) begin
            pc_d         = redirect_pc;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            out_valid_q  <= 1'b0;
            out_instr_q  <= 32'h0;
            out_pc_q     <= 32'h0;
            out_pc4_q    <= 32'h0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            out_pc4_q    <= out_pc4_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // NOTE: skid payload is qualified by skid_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        skid_instr_q <= skid_instr_d;
        skid_pc_q    <= skid_pc_d;
    end

    assign id_valid       = out_valid_q;
    assign id_instruction = out_instr_q;
    assign id_pc          = out_pc_q;
    assign id_pc_plus4    = out_pc4_q;
`ifdef IF_ADDR_CHECK_EN
    assign id_addr_err    = out_err_q;
`else
    assign id_addr_err    = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed steps followed by a randomized phase,
// with the delivered stream checked against a sequential-PC reference model.
module tb_if_stage;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_addr_err;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instruction (id_instruction),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_addr_err    (id_addr_err)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Instruction memory: fixed latency (ack after lat wait cycles) or random ack per cycle.
    int   lat       = 0;
    bit   rand_mode = 1'b0;
    bit   ack_bit   = 1'b0;
    int   wait_cnt  = 0;
    assign imem_ack   = imem_req && (rand_mode ? ack_bit : (wait_cnt >= lat));
    assign imem_rdata = mem_fn(imem_addr);
    always @(posedge clk) begin
        if (rst || !imem_req || imem_ack) wait_cnt <= 0;
        else                              wait_cnt <= wait_cnt + 1;
    end

    // Reference model: delivered entries are consecutive PCs starting at the last reset/redirect.
    logic [31:0] sb_pc     = RESET_PC;
    bit          sb_halted = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            sb_pc     = RESET_PC;
            sb_halted = 1'b0;
        end else begin
            if (sb_halted) begin
                check("halt_idle", 32'(id_valid), 32'h0);
            end else if (id_valid && id_ready) begin
                check("xfer_pc", id_pc, sb_pc);
                check("xfer_pc4", id_pc_plus4, sb_pc + 32'd4);
`ifdef IF_ADDR_CHECK_EN
                if (sb_pc[1:0] != 2'b00) begin
                    check("xfer_err_instr", id_instruction, 32'h0);
                    check("xfer_err_flag", 32'(id_addr_err), 32'h1);
                    sb_halted = 1'b1;
                end else
`endif
                begin
                    check("xfer_instr", id_instruction, mem_fn(sb_pc));
                    check("xfer_err_flag", 32'(id_addr_err), 32'h0);
                end
                sb_pc = sb_pc + 32'd4;
            end
            if (redirect_valid) begin
                sb_pc     = redirect_pc;
                sb_halted = 1'b0;
            end
        end
    end

    // Protocol monitors: output hold under stall, request hold until ack, flush after redirect.
    bit          prev_stall = 1'b0;
    bit          prev_pend  = 1'b0;
    bit          prev_redir = 1'b0;
    logic [31:0] prev_pc    = '0;
    logic [31:0] prev_instr = '0;
    logic [31:0] prev_addr  = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                check("hold_valid", 32'(id_valid), 32'h1);
                check("hold_pc", id_pc, prev_pc);
                check("hold_instr", id_instruction, prev_instr);
            end
            if (prev_pend) begin
                check("req_hold", 32'(imem_req), 32'h1);
                check("req_addr_hold", imem_addr, prev_addr);
            end
            if (prev_redir) check("redir_flush", 32'(id_valid), 32'h0);
        end
        prev_stall = !rst && id_valid && !id_ready && !redirect_valid;
        prev_pend  = !rst && imem_req && !imem_ack;
        prev_redir = !rst && redirect_valid;
        prev_pc    = id_pc;
        prev_instr = id_instruction;
        prev_addr  = imem_addr;
    end

    logic [31:0] stall_pc;

    initial begin
        rst            = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state
        repeat (3) begin
            cyc();
            @(negedge clk);
            check("rst_req", 32'(imem_req), 32'h0);
            check("rst_valid", 32'(id_valid), 32'h0);
        end
        check("rst_instr", id_instruction, 32'h0);
        check("rst_pc", id_pc, 32'h0);
        check("rst_pc4", id_pc_plus4, 32'h0);
        check("rst_err", 32'(id_addr_err), 32'h0);

        // Single-cycle memory, back-to-back stream from RESET_PC
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("seq_req", 32'(imem_req), 32'h1);
            check("seq_addr", imem_addr, RESET_PC + 32'(4 * i));
            check("seq_valid", 32'(id_valid), 32'(i != 0));
            if (i > 0) begin
                check("seq_pc", id_pc, RESET_PC + 32'(4 * (i - 1)));
                check("seq_pc4", id_pc_plus4, RESET_PC + 32'(4 * i));
            end
            cyc();
        end

        // Five-cycle decoder stall: skid absorbs one fetch, then requests stop
        stall_pc = sb_pc;
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_pc", id_pc, stall_pc);
            check("stall_req", 32'(imem_req), 32'(i == 0));
            if (i == 0) check("stall_addr", imem_addr, stall_pc + 32'd4);
            cyc();
        end
        id_ready = 1'b1;
        @(negedge clk);
        check("release_req", 32'(imem_req), 32'h0);
        check("release_pc", id_pc, stall_pc);
        cyc();
        @(negedge clk);
        check("release_pc2", id_pc, stall_pc + 32'd4);
        check("resume_addr", imem_addr, stall_pc + 32'd8);
        cyc();
        repeat (2) cyc();

        // Redirect coinciding with ack and ID transfer
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1000;
        @(negedge clk);
        check("rd_pre_valid", 32'(id_valid), 32'h1);
        check("rd_pre_ack", 32'(imem_ack), 32'h1);
        cyc();
        redirect_valid = 1'b0;
        lat            = 2;
        @(negedge clk);
        check("rd_next_addr", imem_addr, 32'h0000_1000);
        check("rd_next_req", 32'(imem_req), 32'h1);
        cyc();

        // Redirect during a 3-cycle fetch: old address held until ack, data dropped
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        @(negedge clk);
        check("kill_addr0", imem_addr, 32'h0000_1000);
        check("kill_ack0", 32'(imem_ack), 32'h0);
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("kill_addr1", imem_addr, 32'h0000_1000);
        check("kill_ack1", 32'(imem_ack), 32'h1);
        cyc();
        @(negedge clk);
        check("kill_new_req", 32'(imem_req), 32'h1);
        check("kill_new_addr", imem_addr, 32'h8000_0100);
        check("kill_no_data", 32'(id_valid), 32'h0);
        cyc();
        repeat (2) cyc();
        @(negedge clk);
        check("kill_first_valid", 32'(id_valid), 32'h1);
        check("kill_first_pc", id_pc, 32'h8000_0100);
        cyc();

        // Reset during an outstanding fetch
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req0", 32'(imem_req), 32'h0);
        cyc();
        @(negedge clk);
        check("midrst_req1", 32'(imem_req), 32'h0);
        check("midrst_valid", 32'(id_valid), 32'h0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_restart_req", 32'(imem_req), 32'h1);
        check("midrst_restart_addr", imem_addr, RESET_PC);
        cyc();
        repeat (2) cyc();
        @(negedge clk);
        check("midrst_first_pc", id_pc, RESET_PC);
        check("midrst_first_valid", 32'(id_valid), 32'h1);
        cyc();

        // Misaligned redirect target
        lat            = 0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
`ifdef IF_ADDR_CHECK_EN
        check("mis_no_req", 32'(imem_req), 32'h0);
        cyc();
        @(negedge clk);
        check("mis_valid", 32'(id_valid), 32'h1);
        check("mis_err", 32'(id_addr_err), 32'h1);
        check("mis_instr", id_instruction, 32'h0);
        check("mis_pc", id_pc, 32'h8000_0102);
        cyc();
        repeat (3) begin
            @(negedge clk);
            check("halt_req", 32'(imem_req), 32'h0);
            check("halt_valid", 32'(id_valid), 32'h0);
            cyc();
        end
`else
        check("mis_req", 32'(imem_req), 32'h1);
        check("mis_addr", imem_addr, 32'h8000_0102);
        cyc();
        @(negedge clk);
        check("mis_valid", 32'(id_valid), 32'h1);
        check("mis_err", 32'(id_addr_err), 32'h0);
        check("mis_pc", id_pc, 32'h8000_0102);
        cyc();
`endif

        // Address wrap from 0xFFFF_FFFC to 0
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        cyc();
        cyc();
        @(negedge clk);
        check("wrap_addr", imem_addr, 32'h0000_0000);
        check("wrap_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", id_pc_plus4, 32'h0000_0000);
        cyc();

        // Randomized ready/ack/redirect traffic
        rand_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            id_ready       = ($urandom_range(0, 9) < 7);
            ack_bit        = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = 32'($urandom()) & 32'hFFFF_FFFC;
            cyc();
        end
        rand_mode      = 1'b0;
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        repeat (10) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
